// File: rtl/edge_pkg.sv
// Shared types, default sizes and the round-robin pick helper for edge_event_arbiter.
package edge_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int DEF_N     = 2;
  localparam int DEF_CNT_W = 3;
  // Upper bound on channel count accepted by rr_next.
  localparam int MAX_N     = 32;

  // First requesting channel strictly after ptr, wrapping from n-1 to 0.
  // When nothing requests, ptr is returned unchanged.
  function automatic int unsigned rr_next(input logic [MAX_N-1:0] req,
                                          input int unsigned      n,
                                          input int unsigned      ptr);
    int unsigned res;
    logic        found;
    res   = ptr;
    found = 1'b0;
    for (int unsigned j = 0; j < MAX_N; j++) begin
      if (!found && j > ptr && j < n && req[j]) begin
        res   = j;
        found = 1'b1;
      end
    end
    for (int unsigned j = 0; j < MAX_N; j++) begin
      if (!found && j <= ptr && j < n && req[j]) begin
        res   = j;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_pend_counter.sv
// One channel: rising-edge detect, saturating pending-event counter and sticky overflow flag.
module edge_pend_counter
  import edge_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  input  logic dec_i,
  input  logic clr_ovf_i,
  output logic nz_o,
  output logic nz_d_o,
  output logic ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             edge_det;

  // Edge detect and counter/flag next state; a saturated edge sets overflow even during a clear.
  always_comb begin
    edge_det = in_i & ~prev_q;
    prev_d   = in_i;
    pend_d   = pend_q;
    ovf_d    = clr_ovf_i ? 1'b0 : ovf_q;
    if (edge_det && !dec_i) begin
      if (pend_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + CNT_W'(1);
      end
    end else if (!edge_det && dec_i && pend_q != '0) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  // Channel state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign nz_o   = (pend_q != '0);
  assign nz_d_o = (pend_d != '0);
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge queues feeding a round-robin grant/ack arbiter for one shared handler.
module edge_event_arbiter
  import edge_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ID_W  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    entrada,
  input  logic            ack,
  input  logic            clr_overflow,
  output logic            grant_valid,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            pending_any,
  output logic [N-1:0]    overflow
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic            pending_any_q;

  logic [N-1:0]    req;
  logic [N-1:0]    pend_nz_d;
  logic [N-1:0]    dec;
  int unsigned     sel;

  // Only an acknowledged, outstanding grant consumes a pending event.
  assign dec = grant_q & {N{grant_valid_q & ack}};

  for (genvar g = 0; g < N; g++) begin : g_ch
    edge_pend_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .in_i     (entrada[g]),
      .dec_i    (dec[g]),
      .clr_ovf_i(clr_overflow),
      .nz_o     (req[g]),
      .nz_d_o   (pend_nz_d[g]),
      .ovf_o    (overflow[g])
    );
  end

  // Grant FSM: decide from registered counts in IDLE, hold in GRANT until ack.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    sel           = rr_next(MAX_N'(req), N, 32'(rr_ptr_q));
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d       = GRANT;
          grant_valid_d = 1'b1;
          grant_id_d    = ID_W'(sel);
          grant_d       = N'(1) << grant_id_d;
          rr_ptr_d      = grant_id_d;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          grant_d       = '0;
          grant_id_d    = '0;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
        grant_d       = '0;
        grant_id_d    = '0;
      end
    endcase
  end

  // Arbiter registers; pending_any tracks the counters' next state so it lines up with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= ID_W'(N - 1);
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      pending_any_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      pending_any_q <= |pend_nz_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign pending_any = pending_any_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=2, CNT_W=3).
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] entrada;
  logic       ack;
  logic       clr_overflow;
  logic       grant_valid;
  logic [1:0] grant;
  logic [0:0] grant_id;
  logic       pending_any;
  logic [1:0] overflow;

  int n_assert = 0;
  int n_fail   = 0;

  edge_event_arbiter #(.N(2), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .entrada     (entrada),
    .ack         (ack),
    .clr_overflow(clr_overflow),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_id    (grant_id),
    .pending_any (pending_any),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic gv, input logic [1:0] g,
                           input logic id);
    chk({tag, ".valid"}, 32'(grant_valid), 32'(gv));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".id"}, 32'(grant_id), 32'(id));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; entrada = 2'b00; ack = 1'b0; clr_overflow = 1'b0;
    #3;
    chk_grant("reset", 1'b0, 2'b00, 1'b0);
    chk("reset.pa", 32'(pending_any), 32'd0);
    chk("reset.ovf", 32'(overflow), 32'd0);
    step(); step();
    rst = 1'b1;

    // Single pulse on channel 0.
    entrada = 2'b01; step();
    chk("t1.pa_after_edge", 32'(pending_any), 32'd1);
    chk("t1.no_grant_yet", 32'(grant_valid), 32'd0);
    entrada = 2'b00; step();
    chk_grant("t1.grant", 1'b1, 2'b01, 1'b0);
    ack = 1'b1; step();
    ack = 1'b0;
    chk_grant("t1.after_ack", 1'b0, 2'b00, 1'b0);
    chk("t1.pa_clear", 32'(pending_any), 32'd0);

    // Fresh reset so the pointer starts at N-1, then simultaneous edges.
    rst = 1'b0; #1; rst = 1'b1;
    step();
    entrada = 2'b11; step();
    entrada = 2'b00; step();
    chk_grant("t2.first", 1'b1, 2'b01, 1'b0);
    step();
    chk_grant("t2.first_hold", 1'b1, 2'b01, 1'b0);
    ack = 1'b1; step();
    ack = 1'b0;
    chk("t2.idle_gap", 32'(grant_valid), 32'd0);
    chk("t2.pa_ch1_left", 32'(pending_any), 32'd1);
    step();
    chk_grant("t2.second", 1'b1, 2'b10, 1'b1);
    step();
    ack = 1'b1; step();
    ack = 1'b0;
    chk("t2.pa_done", 32'(pending_any), 32'd0);

    // Fairness: channel 0 re-pulses while granted, channel 1 still gets its turn.
    entrada = 2'b11; step();
    entrada = 2'b00; step();
    chk_grant("t3.g1", 1'b1, 2'b01, 1'b0);
    entrada = 2'b01; step();
    entrada = 2'b00; ack = 1'b1; step();
    ack = 1'b0; step();
    chk_grant("t3.g2", 1'b1, 2'b10, 1'b1);
    ack = 1'b1; step();
    ack = 1'b0; step();
    chk_grant("t3.g3", 1'b1, 2'b01, 1'b0);
    ack = 1'b1; step();
    ack = 1'b0;
    chk("t3.pa_done", 32'(pending_any), 32'd0);

    // Edge coinciding with ack on the granted channel keeps the count at 1.
    entrada = 2'b01; step();
    entrada = 2'b00; step();
    chk_grant("t5.g1", 1'b1, 2'b01, 1'b0);
    entrada = 2'b01; ack = 1'b1; step();
    entrada = 2'b00; ack = 1'b0;
    chk("t5.gap_valid", 32'(grant_valid), 32'd0);
    chk("t5.gap_pa", 32'(pending_any), 32'd1);
    step();
    chk_grant("t5.g2", 1'b1, 2'b01, 1'b0);
    ack = 1'b1; step();
    ack = 1'b0;
    chk("t5.pa_done", 32'(pending_any), 32'd0);

    // Saturation: nine edges, no ack.
    for (int e = 0; e < 9; e++) begin
      entrada = 2'b01; step();
      entrada = 2'b00; step();
    end
    chk_grant("t4.held", 1'b1, 2'b01, 1'b0);
    chk("t4.ovf_set", 32'(overflow), 32'h1);
    clr_overflow = 1'b1; step();
    chk("t4.ovf_clr", 32'(overflow), 32'h0);
    entrada = 2'b01; step();
    chk("t4.set_wins", 32'(overflow), 32'h1);
    entrada = 2'b00; step();
    clr_overflow = 1'b0;
    chk("t4.ovf_clr2", 32'(overflow), 32'h0);
    for (int j = 1; j <= 7; j++) begin
      ack = 1'b1; step();
      ack = 1'b0;
      chk($sformatf("t4.ack%0d_drop", j), 32'(grant_valid), 32'd0);
      step();
      chk($sformatf("t4.ack%0d_next", j), 32'(grant_valid), (j < 7) ? 32'd1 : 32'd0);
    end
    chk("t4.pa_empty", 32'(pending_any), 32'd0);

    // Asynchronous reset mid-grant, line held high through release.
    entrada = 2'b01; step();
    entrada = 2'b00; step();
    chk_grant("t6.granted", 1'b1, 2'b01, 1'b0);
    #3; rst = 1'b0; #1;
    chk_grant("t6.in_reset", 1'b0, 2'b00, 1'b0);
    chk("t6.pa_reset", 32'(pending_any), 32'd0);
    entrada = 2'b01; #2; rst = 1'b1;
    step();
    chk("t6.pa_release", 32'(pending_any), 32'd1);
    chk("t6.no_grant_yet", 32'(grant_valid), 32'd0);
    step();
    chk_grant("t6.grant", 1'b1, 2'b01, 1'b0);
    ack = 1'b1; step();
    ack = 1'b0; step();
    chk("t6.single_grant", 32'(grant_valid), 32'd0);
    chk("t6.pa_done", 32'(pending_any), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
